ctrl_step_sequencer: RTL and testbench
======================================

// Module: ctrl_step_sequencer
// PURPOSE
//   Parametrised fetch/execute step generator for the datapath control unit: emits
//   fetch-phase datapath strobes itself and an execute step index (T3..Tn) for the
//   instruction decoder. Adds variable-length execute and memory-ready handshake
//   with timeout, stall, run/stop control and an instruction counter.
// PARAMETERS
//   STEP_W        4    width of exec_len / exec_step (max 2**STEP_W-1 execute steps)
//   MEM_TIMEOUT   16   cycles without mem_ready in fetch before fault halt (>=2)
//   CNT_W         32   width of instr_count
//   START_RUNNING 1    1: leave reset into F0; 0: leave reset into HALT
// PORTS
//   clk          in  1      clock, all state updates on rising edge
//   reset        in  1      synchronous, active-high reset
//   run          in  1      start/resume from HALT (level sampled; one cycle enough)
//   stop         in  1      request HALT at end of current instruction
//   mem_ready    in  1      memory read data valid this cycle
//   exec_len     in  STEP_W execute steps of current instr (from decoder; 0 treated as 1)
//   exec_stall   in  1      hold current execute step (mul/div, memory ops)
//   pc_out, mar_in, inc_pc, z_in, alu_add  out 1  F0 strobes (alu_add selects ALU Add)
//   z_low_out, pc_in, read, mdr_in         out 1  F1 strobes
//   mdr_out, ir_in                         out 1  F2 strobes
//   exec_active  out 1      in EXEC; decoder drives execute strobes only when high
//   exec_step    out STEP_W current execute step, 0-based
//   running      out 1      0 only in HALT
//   mem_timeout  out 1      sticky fault flag
//   instr_count  out CNT_W  completed instructions, wraps
// BEHAVIOUR
//   States: HALT, F0, F1, F1W, F2, EXEC. All outputs registered-state Moore decodes.
//   Reset: state=F0 if START_RUNNING else HALT; exec_step=0, instr_count=0,
//     mem_timeout=0, stop_pending=0, all strobes 0; running=START_RUNNING.
//   Reset wins over every other input on the same edge, any state, mid-instruction.
//   F0 (1 cycle): pc_out, mar_in, inc_pc, z_in, alu_add =1 -> F1.
//   F1 (1 cycle): z_low_out, pc_in, read, mdr_in =1; mem_ready ? F2 : F1W.
//   F1W: read, mdr_in =1 (pc_in/z_low_out NOT repeated); mem_ready -> F2.
//     wait_cnt counts F1+F1W cycles without mem_ready; at MEM_TIMEOUT -> HALT,
//     mem_timeout<=1. mem_ready on the timeout cycle takes priority (-> F2).
//   F2 (1 cycle): mdr_out, ir_in =1 -> EXEC, exec_step=0.
//   EXEC: exec_active=1. len latched from exec_len on step-0 cycle (0->1); later
//     exec_len changes ignored. exec_stall=1 holds step (stall on any step, incl. 0,
//     does not re-latch len). Unstalled on step len-1: instr_count+1 (mod 2**CNT_W),
//     exec_step<=0, -> HALT if stop or stop_pending, else F0.
//   stop_pending set by stop in F0..EXEC; cleared on entering HALT. stop never aborts
//     a fetch or execute in progress.
//   HALT: all strobes 0, running=0, exec_active=0. run=1 -> F0, mem_timeout<=0,
//     stop_pending<=0. stop in HALT ignored; run and stop together -> F0.
//   Minimum instruction = 4 cycles (F0,F1,F2, one EXEC) with mem_ready in F1.
// TESTING
//   1 reset 3 cycles, START_RUNNING=1, mem_ready=1, exec_len=1 -> F0,F1,F2,EXEC
//     repeating; each strobe one cycle; instr_count 1,2,3 every 4 cycles.
//   2 mem_ready low 3 cycles in F1 -> pc_in high exactly 1 cycle, read/mdr_in 4 cycles,
//     then F2; exec_len=5 with exec_stall at step 2 for 2 cycles -> steps 0,1,2,2,2,3,4.
//   3 mem_ready never -> HALT after 16 fetch-wait cycles, mem_timeout=1, running=0;
//     run pulse -> F0 next cycle, mem_timeout=0.
//   4 stop pulse during F1 -> instruction completes, then HALT, instr_count +1;
//     run and stop same cycle in HALT -> F0.
//   5 reset asserted in EXEC step 3 -> next cycle all strobes 0, exec_step=0,
//     instr_count=0; exec_len=0 -> exactly one EXEC cycle; CNT_W=4 wraps 15->0.

Source files
------------

// File: rtl/ctrl_step_sequencer.sv
// Fetch/execute step generator for the datapath control unit.
// It drives the fetch strobes directly and hands execute step indices to the decoder.
module ctrl_step_sequencer #(
  parameter int STEP_W        = 4,
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 32,
  parameter int START_RUNNING = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stop,
  input  logic              mem_ready,
  input  logic [STEP_W-1:0] exec_len,
  input  logic              exec_stall,
  output logic              pc_out,
  output logic              mar_in,
  output logic              inc_pc,
  output logic              z_in,
  output logic              alu_add,
  output logic              z_low_out,
  output logic              pc_in,
  output logic              read,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              ir_in,
  output logic              exec_active,
  output logic [STEP_W-1:0] exec_step,
  output logic              running,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_HALT,
    S_F0,
    S_F1,
    S_F1W,
    S_F2,
    S_EXEC
  } state_t;

  localparam int     WAIT_W      = $clog2(MEM_TIMEOUT);
  localparam state_t RESET_STATE = (START_RUNNING != 0) ? S_F0 : S_HALT;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   exec_step_q, exec_step_d;
  logic [STEP_W-1:0]   len_q, len_d;
  logic                len_valid_q, len_valid_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    instr_count_q, instr_count_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                stop_pending_q, stop_pending_d;
  logic [STEP_W-1:0]   eff_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RESET_STATE;
      exec_step_q    <= '0;
      len_q          <= '0;
      len_valid_q    <= 1'b0;
      wait_cnt_q     <= '0;
      instr_count_q  <= '0;
      mem_timeout_q  <= 1'b0;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      exec_step_q    <= exec_step_d;
      len_q          <= len_d;
      len_valid_q    <= len_valid_d;
      wait_cnt_q     <= wait_cnt_d;
      instr_count_q  <= instr_count_d;
      mem_timeout_q  <= mem_timeout_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  // Length is taken live on the first EXEC cycle, then frozen until the next F2.
  always_comb begin
    state_d       = state_q;
    exec_step_d   = exec_step_q;
    len_d         = len_q;
    len_valid_d   = len_valid_q;
    wait_cnt_d    = wait_cnt_q;
    instr_count_d = instr_count_q;
    mem_timeout_d = mem_timeout_q;
    eff_len       = len_valid_q ? len_q
                  : ((exec_len == '0) ? STEP_W'(1) : exec_len);
    case (state_q)
      S_HALT: begin
        if (run) begin
          state_d       = S_F0;
          mem_timeout_d = 1'b0;
        end
      end
      S_F0: begin
        state_d    = S_F1;
        wait_cnt_d = '0;
      end
      S_F1, S_F1W: begin
        if (mem_ready) begin
          state_d = S_F2;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d       = S_HALT;
          mem_timeout_d = 1'b1;
        end else begin
          state_d    = S_F1W;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_F2: begin
        state_d     = S_EXEC;
        exec_step_d = '0;
        len_valid_d = 1'b0;
      end
      S_EXEC: begin
        len_d       = eff_len;
        len_valid_d = 1'b1;
        if (!exec_stall) begin
          if (exec_step_q == eff_len - STEP_W'(1)) begin
            exec_step_d   = '0;
            instr_count_d = instr_count_q + CNT_W'(1);
            state_d       = (stop || stop_pending_q) ? S_HALT : S_F0;
          end else begin
            exec_step_d = exec_step_q + STEP_W'(1);
          end
        end
      end
      default: state_d = S_HALT;
    endcase
    stop_pending_d = ((state_q == S_HALT) || (state_d == S_HALT)) ? 1'b0
                   : (stop_pending_q | stop);
  end

  // Strobes stay quiet while reset is held so the datapath sees no fetch until release.
  always_comb begin
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    z_in      = 1'b0;
    alu_add   = 1'b0;
    z_low_out = 1'b0;
    pc_in     = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_F0: begin
          pc_out  = 1'b1;
          mar_in  = 1'b1;
          inc_pc  = 1'b1;
          z_in    = 1'b1;
          alu_add = 1'b1;
        end
        S_F1: begin
          z_low_out = 1'b1;
          pc_in     = 1'b1;
          read      = 1'b1;
          mdr_in    = 1'b1;
        end
        S_F1W: begin
          read   = 1'b1;
          mdr_in = 1'b1;
        end
        S_F2: begin
          mdr_out = 1'b1;
          ir_in   = 1'b1;
        end
        default: ;
      endcase
    end
    exec_active = (state_q == S_EXEC);
    running     = (state_q != S_HALT);
  end

  assign exec_step   = exec_step_q;
  assign mem_timeout = mem_timeout_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Scoreboard bench for ctrl_step_sequencer: stimulus pushes the expected output word,
// a monitor pops and compares one word after every rising edge.
module tb_ctrl_step_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       stop = 1'b0;
  logic       mem_ready = 1'b1;
  logic [3:0] exec_len = 4'd1;
  logic       exec_stall = 1'b0;

  logic       pc_out, mar_in, inc_pc, z_in, alu_add;
  logic       z_low_out, pc_in, read, mdr_in, mdr_out, ir_in;
  logic       exec_active, running, mem_timeout;
  logic [3:0] exec_step;
  logic [3:0] instr_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];
  logic [21:0] got;

  ctrl_step_sequencer #(
    .STEP_W(4), .MEM_TIMEOUT(16), .CNT_W(4), .START_RUNNING(1)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .stop(stop), .mem_ready(mem_ready),
    .exec_len(exec_len), .exec_stall(exec_stall),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .alu_add(alu_add),
    .z_low_out(z_low_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .exec_active(exec_active), .exec_step(exec_step),
    .running(running), .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign got = {pc_out, mar_in, inc_pc, z_in, alu_add, z_low_out, pc_in, read, mdr_in,
                mdr_out, ir_in, exec_active, exec_step, running, mem_timeout, instr_count};

  function automatic logic [21:0] mkv(logic [10:0] s, logic a, logic [3:0] st,
                                      logic r, logic t, logic [3:0] c);
    return {s, a, st, r, t, c};
  endfunction
  function automatic logic [21:0] vRst();
    return mkv(11'b00000_0000_00, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
  endfunction
  function automatic logic [21:0] vF0(logic [3:0] c);
    return mkv(11'b11111_0000_00, 1'b0, 4'd0, 1'b1, 1'b0, c);
  endfunction
  function automatic logic [21:0] vF1(logic [3:0] c);
    return mkv(11'b00000_1111_00, 1'b0, 4'd0, 1'b1, 1'b0, c);
  endfunction
  function automatic logic [21:0] vF1W(logic [3:0] c);
    return mkv(11'b00000_0011_00, 1'b0, 4'd0, 1'b1, 1'b0, c);
  endfunction
  function automatic logic [21:0] vF2(logic [3:0] c);
    return mkv(11'b00000_0000_11, 1'b0, 4'd0, 1'b1, 1'b0, c);
  endfunction
  function automatic logic [21:0] vEx(logic [3:0] st, logic [3:0] c);
    return mkv(11'b00000_0000_00, 1'b1, st, 1'b1, 1'b0, c);
  endfunction
  function automatic logic [21:0] vHalt(logic [3:0] c, logic t);
    return mkv(11'b00000_0000_00, 1'b0, 4'd0, 1'b0, t, c);
  endfunction

  task automatic applyStimulus(input logic rst, input logic rn, input logic sp,
                               input logic mr, input logic [3:0] len, input logic stl,
                               input logic [21:0] exp, input string nm);
    @(negedge clk);
    reset      = rst;
    run        = rn;
    stop       = sp;
    mem_ready  = mr;
    exec_len   = len;
    exec_stall = stl;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic checkOutput();
    logic [21:0] e;
    string       nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, got, e, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) checkOutput();
    end
  end

  initial begin
    // back-to-back single-step instructions after reset
    repeat (3) applyStimulus(1, 0, 0, 1, 4'd1, 0, vRst(), "reset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 4'd1, 0, vF1(4'(i)), "t1_f1");
      applyStimulus(0, 0, 0, 1, 4'd1, 0, vF2(4'(i)), "t1_f2");
      applyStimulus(0, 0, 0, 1, 4'd1, 0, vEx(4'd0, 4'(i)), "t1_ex");
      applyStimulus(0, 0, 0, 1, 4'd1, 0, vF0(4'(i + 1)), "t1_f0");
    end

    // memory wait, then a stalled five-step execute with exec_len changing mid-way
    applyStimulus(0, 0, 0, 0, 4'd1, 0, vF1(4'd3), "t2_f1");
    repeat (3) applyStimulus(0, 0, 0, 0, 4'd1, 0, vF1W(4'd3), "t2_f1w");
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vF2(4'd3), "t2_f2");
    applyStimulus(0, 0, 0, 1, 4'd5, 0, vEx(4'd0, 4'd3), "t2_step0");
    applyStimulus(0, 0, 0, 1, 4'd5, 0, vEx(4'd1, 4'd3), "t2_step1");
    applyStimulus(0, 0, 0, 1, 4'd2, 0, vEx(4'd2, 4'd3), "t2_step2");
    applyStimulus(0, 0, 0, 1, 4'd2, 1, vEx(4'd2, 4'd3), "t2_stall_a");
    applyStimulus(0, 0, 0, 1, 4'd2, 1, vEx(4'd2, 4'd3), "t2_stall_b");
    applyStimulus(0, 0, 0, 1, 4'd2, 0, vEx(4'd3, 4'd3), "t2_step3");
    applyStimulus(0, 0, 0, 1, 4'd2, 0, vEx(4'd4, 4'd3), "t2_step4");
    applyStimulus(0, 0, 0, 1, 4'd2, 0, vF0(4'd4), "t2_done");

    // memory never ready: fault halt after 16 wait cycles, run clears it
    applyStimulus(0, 0, 0, 0, 4'd1, 0, vF1(4'd4), "t3_f1");
    repeat (15) applyStimulus(0, 0, 0, 0, 4'd1, 0, vF1W(4'd4), "t3_f1w");
    applyStimulus(0, 0, 0, 0, 4'd1, 0, vHalt(4'd4, 1'b1), "t3_timeout");
    applyStimulus(0, 0, 0, 0, 4'd1, 0, vHalt(4'd4, 1'b1), "t3_halt_hold");
    applyStimulus(0, 1, 0, 1, 4'd1, 0, vF0(4'd4), "t3_resume");

    // stop during F1 finishes the instruction, stop alone in HALT is ignored
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vF1(4'd4), "t4_f1");
    applyStimulus(0, 0, 1, 1, 4'd1, 0, vF2(4'd4), "t4_f2");
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vEx(4'd0, 4'd4), "t4_ex");
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vHalt(4'd5, 1'b0), "t4_halt");
    applyStimulus(0, 0, 1, 1, 4'd1, 0, vHalt(4'd5, 1'b0), "t4_stop_in_halt");
    applyStimulus(0, 1, 1, 1, 4'd1, 0, vF0(4'd5), "t4_run_stop");

    // mem_ready arriving on the timeout cycle still completes the fetch
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vF1(4'd5), "t3b_f1");
    repeat (15) applyStimulus(0, 0, 0, 0, 4'd1, 0, vF1W(4'd5), "t3b_f1w");
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vF2(4'd5), "t3b_late_ready");
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vEx(4'd0, 4'd5), "t3b_ex");
    applyStimulus(0, 0, 0, 1, 4'd1, 0, vF0(4'd6), "t3b_f0");

    // reset mid-execute, zero-length execute, counter wrap
    applyStimulus(0, 0, 0, 1, 4'd6, 0, vF1(4'd6), "t5_f1");
    applyStimulus(0, 0, 0, 1, 4'd6, 0, vF2(4'd6), "t5_f2");
    applyStimulus(0, 0, 0, 1, 4'd6, 0, vEx(4'd0, 4'd6), "t5_step0");
    applyStimulus(0, 0, 0, 1, 4'd6, 0, vEx(4'd1, 4'd6), "t5_step1");
    applyStimulus(0, 0, 0, 1, 4'd6, 0, vEx(4'd2, 4'd6), "t5_step2");
    applyStimulus(0, 0, 0, 1, 4'd6, 0, vEx(4'd3, 4'd6), "t5_step3");
    applyStimulus(1, 0, 0, 1, 4'd6, 0, vRst(), "t5_reset");
    applyStimulus(1, 0, 0, 1, 4'd6, 0, vRst(), "t5_reset_hold");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 1, 4'd0, 0, vF1(4'(i)), "t5_f1");
      applyStimulus(0, 0, 0, 1, 4'd0, 0, vF2(4'(i)), "t5_f2");
      applyStimulus(0, 0, 0, 1, 4'd0, 0, vEx(4'd0, 4'(i)), "t5_len0");
      applyStimulus(0, 0, 0, 1, 4'd0, 0, vF0(4'(i + 1)), "t5_count");
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
